// File: rtl/ntt_mem_pkg.sv
// Shared definitions for the banked NTT coefficient/twiddle memories.
package ntt_mem_pkg;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_e;

  // Low bit of bank idx inside a flat bus of width-w slices.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/bram_bank.sv
// One simple-dual-port bank: memory array, write/read collision bypass and
// the 1- or 2-stage read pipeline with its valid flag.
module bram_bank
  import ntt_mem_pkg::*;
#(
  parameter int unsigned DLEN        = 32,
  parameter int unsigned HLEN        = 9,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned WRITE_FIRST = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [HLEN-1:0] wa,
  input  logic [DLEN-1:0] wd,
  input  logic            re,
  input  logic [HLEN-1:0] ra,
  output logic [DLEN-1:0] rd,
  output logic            rv
);

  localparam int unsigned DEPTH = 1 << HLEN;

  logic [DLEN-1:0] mem [DEPTH];
  logic [DLEN-1:0] q1;
  logic            v1;
  logic            bypass;

  assign bypass = (WRITE_FIRST != 0) && we && (wa == ra);

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Without the bypass, mem[ra] samples the pre-write contents on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= re;
      if (re) q1 <= bypass ? wd : mem[ra];
    end
  end

  if (RD_LAT >= RD_LAT_MAX) begin : g_pipe
    logic [DLEN-1:0] q2;
    logic            v2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q2 <= '0;
        v2 <= 1'b0;
      end else begin
        v2 <= v1;
        if (v1) q2 <= q1;
      end
    end

    assign rd = q2;
    assign rv = v2;
  end else begin : g_direct
    assign rd = q1;
    assign rv = v1;
  end

endmodule

// File: rtl/bram_banked.sv
// BANKS-wide simple-dual-port RAM with a sequential clear engine that zeroes
// every bank, one address per cycle, after a clr pulse.
module bram_banked
  import ntt_mem_pkg::*;
#(
  parameter int unsigned DLEN        = 32,
  parameter int unsigned HLEN        = 9,
  parameter int unsigned BANKS       = 4,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned WRITE_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BANKS-1:0]      wen,
  input  logic [BANKS*HLEN-1:0] waddr,
  input  logic [BANKS*DLEN-1:0] din,
  input  logic [BANKS-1:0]      ren,
  input  logic [BANKS*HLEN-1:0] raddr,
  output logic [BANKS*DLEN-1:0] dout,
  output logic [BANKS-1:0]      dvalid,
  input  logic                  clr,
  output logic                  busy
);

  localparam logic [HLEN:0] LAST_ADDR = {1'b0, {HLEN{1'b1}}};

  clr_state_e    state, state_nxt;
  logic [HLEN:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (clr) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_ADDR) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_CLEAR);

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    localparam int unsigned AOFS = slice_lo(b, HLEN);
    localparam int unsigned DOFS = slice_lo(b, DLEN);

    logic            we;
    logic [HLEN-1:0] wa;
    logic [DLEN-1:0] wd;
    logic            re;

    // The clear engine owns the write port and blocks new reads while busy.
    always_comb begin
      we = wen[b];
      wa = waddr[AOFS +: HLEN];
      wd = din[DOFS +: DLEN];
      re = ren[b];
      if (busy) begin
        we = 1'b1;
        wa = cnt[HLEN-1:0];
        wd = '0;
        re = 1'b0;
      end
    end

    bram_bank #(
      .DLEN        (DLEN),
      .HLEN        (HLEN),
      .RD_LAT      (RD_LAT),
      .WRITE_FIRST (WRITE_FIRST)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .wa    (wa),
      .wd    (wd),
      .re    (re),
      .ra    (raddr[AOFS +: HLEN]),
      .rd    (dout[DOFS +: DLEN]),
      .rv    (dvalid[b])
    );
  end

endmodule
